iopmp_cfg_axil_bridge: RTL



---
 rtl/iopmp_cfg_axil_bridge.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/iopmp_cfg_axil_bridge.sv
// AXI4-Lite responder for the IOPMP configuration window.
// Each accepted transaction becomes one single-cycle access on the iopmp config port.
module iopmp_cfg_axil_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] CFG_ADDR_BASE = AXI_ADDR_WIDTH'(32'h5000_0000)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic [AXI_ADDR_WIDTH-1:0]   address_cfg,
  output logic                        en_cfg,
  output logic                        we_cfg,
  output logic [AXI_DATA_WIDTH-1:0]   wdata_cfg,
  input  logic [AXI_DATA_WIDTH-1:0]   rdata_cfg
);

  localparam int unsigned STRB_WIDTH  = AXI_DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_EXEC,
    WR_RESP,
    RD_EXEC,
    RD_RESP
  } state_t;

  state_t state;

  logic                      aw_full, w_full, ar_full;
  logic [AXI_ADDR_WIDTH-1:0] aw_buf, ar_buf;
  logic [AXI_DATA_WIDTH-1:0] w_buf;
  logic [STRB_WIDTH-1:0]     wstrb_buf;
  logic                      prio_wr;

  logic                      aw_hs, w_hs, ar_hs;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_cur, ar_addr_cur;
  logic [AXI_DATA_WIDTH-1:0] w_data_cur;
  logic [STRB_WIDTH-1:0]     w_strb_cur;
  logic                      wr_pend, rd_pend, grant_wr, grant_rd;
  logic [1:0]                wr_dec, rd_dec;
  logic                      aw_full_n, w_full_n, ar_full_n;

  // Window decode: base match first, then alignment and full-strobe checks.
  function automatic logic [1:0] decode(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                        input logic strb_ok);
    if (addr[AXI_ADDR_WIDTH-1:16] != CFG_ADDR_BASE[AXI_ADDR_WIDTH-1:16])
      return RESP_DECERR;
    else if ((addr[1:0] != 2'b00) || !strb_ok)
      return RESP_SLVERR;
    else
      return RESP_OKAY;
  endfunction

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  // Bypass the buffers so a request arriving in IDLE executes on the next cycle.
  assign aw_addr_cur = aw_full ? aw_buf    : s_awaddr;
  assign w_data_cur  = w_full  ? w_buf     : s_wdata;
  assign w_strb_cur  = w_full  ? wstrb_buf : s_wstrb;
  assign ar_addr_cur = ar_full ? ar_buf    : s_araddr;

  assign wr_pend  = (aw_full | aw_hs) & (w_full | w_hs);
  assign rd_pend  = ar_full | ar_hs;
  assign grant_wr = wr_pend & (~rd_pend | prio_wr);
  assign grant_rd = rd_pend & (~wr_pend | ~prio_wr);

  assign wr_dec = decode(aw_addr_cur, &w_strb_cur);
  assign rd_dec = decode(ar_addr_cur, 1'b1);

  assign aw_full_n = (state != WR_EXEC) & (aw_full | aw_hs);
  assign w_full_n  = (state != WR_EXEC) & (w_full | w_hs);
  assign ar_full_n = (state != RD_EXEC) & (ar_full | ar_hs);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      ar_full     <= 1'b0;
      aw_buf      <= '0;
      w_buf       <= '0;
      wstrb_buf   <= '0;
      ar_buf      <= '0;
      prio_wr     <= 1'b1;
      s_awready   <= 1'b0;
      s_wready    <= 1'b0;
      s_arready   <= 1'b0;
      s_bvalid    <= 1'b0;
      s_bresp     <= RESP_OKAY;
      s_rvalid    <= 1'b0;
      s_rresp     <= RESP_OKAY;
      s_rdata     <= '0;
      en_cfg      <= 1'b0;
      we_cfg      <= 1'b0;
      address_cfg <= '0;
      wdata_cfg   <= '0;
    end else begin
      en_cfg    <= 1'b0;
      we_cfg    <= 1'b0;
      aw_full   <= aw_full_n;
      w_full    <= w_full_n;
      ar_full   <= ar_full_n;
      s_awready <= ~aw_full_n;
      s_wready  <= ~w_full_n;
      s_arready <= ~ar_full_n;
      if (aw_hs) aw_buf <= s_awaddr;
      if (w_hs) begin
        w_buf     <= s_wdata;
        wstrb_buf <= s_wstrb;
      end
      if (ar_hs) ar_buf <= s_araddr;

      case (state)
        IDLE: begin
          if (grant_wr) begin
            state   <= WR_EXEC;
            s_bresp <= wr_dec;
            if (rd_pend) prio_wr <= 1'b0;
            if (wr_dec == RESP_OKAY) begin
              en_cfg      <= 1'b1;
              we_cfg      <= 1'b1;
              address_cfg <= aw_addr_cur;
              wdata_cfg   <= w_data_cur;
            end
          end else if (grant_rd) begin
            state   <= RD_EXEC;
            s_rresp <= rd_dec;
            if (wr_pend) prio_wr <= 1'b1;
            if (rd_dec == RESP_OKAY) begin
              en_cfg      <= 1'b1;
              address_cfg <= ar_addr_cur;
            end
          end
        end
        WR_EXEC: begin
          state    <= WR_RESP;
          s_bvalid <= 1'b1;
        end
        WR_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_EXEC: begin
          state    <= RD_RESP;
          s_rvalid <= 1'b1;
          s_rdata  <= (s_rresp == RESP_OKAY) ? rdata_cfg : '0;
        end
        RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
